// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every mux select, write enable and ALU function code.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        s_fetch  = 4'd0,
        s_decode = 4'd1,
        s_memadr = 4'd2,
        s_memrd  = 4'd3,
        s_memwb  = 4'd4,
        s_memwr  = 4'd5,
        s_exec   = 4'd6,
        s_aluwb  = 4'd7,
        s_branch = 4'd8,
        s_addiex = 4'd9,
        s_addiwb = 4'd10,
        s_jump   = 4'd11
    } state_t;

    localparam logic [5:0] op_rtype = 6'b000000;
    localparam logic [5:0] op_lw    = 6'b100011;
    localparam logic [5:0] op_sw    = 6'b101011;
    localparam logic [5:0] op_beq   = 6'b000100;
    localparam logic [5:0] op_addi  = 6'b001000;
    localparam logic [5:0] op_j     = 6'b000010;

    localparam logic [5:0] fn_add = 6'b100000;
    localparam logic [5:0] fn_sub = 6'b100010;
    localparam logic [5:0] fn_and = 6'b100100;
    localparam logic [5:0] fn_or  = 6'b100101;
    localparam logic [5:0] fn_slt = 6'b101010;

    localparam logic [2:0] alu_add = 3'b010;
    localparam logic [2:0] alu_sub = 3'b110;
    localparam logic [2:0] alu_and = 3'b000;
    localparam logic [2:0] alu_or  = 3'b001;
    localparam logic [2:0] alu_slt = 3'b111;

    state_t state_q;
    state_t state_d;

    logic       funct_ok;
    logic [2:0] funct_alu;

    logic [2:0] alu_control_r;
    logic       alu_src_a_r;
    logic [1:0] alu_src_b_r;
    logic [1:0] pc_src_r;
    logic       pc_write_r;
    logic       branch_r;
    logic       iord_r;
    logic       mem_write_r;
    logic       ir_write_r;
    logic       reg_dst_r;
    logic       mem_to_reg_r;
    logic       reg_write_r;
    logic       illegal_r;

    // R-type function decode; funct_ok gates entry into EXEC so EXEC never sees
    // an unsupported funct.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = alu_add;
        case (funct)
            fn_add:  funct_alu = alu_add;
            fn_sub:  funct_alu = alu_sub;
            fn_and:  funct_alu = alu_and;
            fn_or:   funct_alu = alu_or;
            fn_slt:  funct_alu = alu_slt;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= s_fetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = s_fetch;
        alu_control_r = alu_add;
        alu_src_a_r   = 1'b0;
        alu_src_b_r   = 2'b00;
        pc_src_r      = 2'b00;
        pc_write_r    = 1'b0;
        branch_r      = 1'b0;
        iord_r        = 1'b0;
        mem_write_r   = 1'b0;
        ir_write_r    = 1'b0;
        reg_dst_r     = 1'b0;
        mem_to_reg_r  = 1'b0;
        reg_write_r   = 1'b0;
        illegal_r     = 1'b0;

        case (state_q)
            s_fetch: begin
                alu_src_b_r = 2'b01;
                ir_write_r  = 1'b1;
                pc_write_r  = 1'b1;
                state_d     = s_decode;
            end
            s_decode: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_b_r = 2'b11;
                case (opcode)
                    op_lw, op_sw: state_d = s_memadr;
                    op_beq:       state_d = s_branch;
                    op_addi:      state_d = s_addiex;
                    op_j:         state_d = s_jump;
                    op_rtype: begin
                        if (funct_ok) begin
                            state_d = s_exec;
                        end else begin
                            illegal_r = 1'b1;
                            state_d   = s_fetch;
                        end
                    end
                    default: begin
                        illegal_r = 1'b1;
                        state_d   = s_fetch;
                    end
                endcase
            end
            s_memadr: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                state_d     = (opcode == op_lw) ? s_memrd : s_memwr;
            end
            s_memrd: begin
                iord_r  = 1'b1;
                state_d = s_memwb;
            end
            s_memwb: begin
                mem_to_reg_r = 1'b1;
                reg_write_r  = 1'b1;
                state_d      = s_fetch;
            end
            s_memwr: begin
                iord_r      = 1'b1;
                mem_write_r = 1'b1;
                state_d     = s_fetch;
            end
            s_exec: begin
                alu_src_a_r   = 1'b1;
                alu_src_b_r   = 2'b00;
                alu_control_r = funct_alu;
                state_d       = s_aluwb;
            end
            s_aluwb: begin
                reg_dst_r   = 1'b1;
                reg_write_r = 1'b1;
                state_d     = s_fetch;
            end
            s_branch: begin
                alu_src_a_r   = 1'b1;
                alu_control_r = alu_sub;
                pc_src_r      = 2'b01;
                branch_r      = 1'b1;
                state_d       = s_fetch;
            end
            s_addiex: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                state_d     = s_addiwb;
            end
            s_addiwb: begin
                reg_write_r = 1'b1;
                state_d     = s_fetch;
            end
            s_jump: begin
                pc_src_r   = 2'b10;
                pc_write_r = 1'b1;
                state_d    = s_fetch;
            end
            default: begin
                state_d = s_fetch;
            end
        endcase
    end

    // Enables are gated by reset_n so nothing writes while reset is held,
    // even though the state register already reads FETCH.
    assign pc_en      = reset_n & (pc_write_r | (branch_r & zero));
    assign ir_write   = reset_n & ir_write_r;
    assign mem_write  = reset_n & mem_write_r;
    assign reg_write  = reset_n & reg_write_r;
    assign illegal_op = reset_n & illegal_r;

    assign alu_control = alu_control_r;
    assign alu_src_a   = alu_src_a_r;
    assign alu_src_b   = alu_src_b_r;
    assign pc_src      = pc_src_r;
    assign iord        = iord_r;
    assign reg_dst     = reg_dst_r;
    assign mem_to_reg  = mem_to_reg_r;
    assign state       = state_q;

endmodule
